sdr_wb_arbiter_2p: RTL

SDR_WB_ARBITER_2P -- requirements
Module: sdr_wb_arbiter_2p

---
 rtl/sdr_wb_arbiter_2p.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/sdr_wb_arbiter_2p.sv
// Two-master round-robin Wishbone arbiter in front of a single SDRAM controller slave port.
// The grant is registered; the selected master's bus is passed through combinationally.
module sdr_wb_arbiter_2p #(
    parameter int unsigned ADR_W = 22,
    parameter int unsigned DAT_W = 32
) (
    input  logic             clk,
    input  logic             rst,

    input  logic [DAT_W-1:0] m0_dat_i,
    input  logic [ADR_W-1:0] m0_adr_i,
    input  logic [3:0]       m0_sel_i,
    input  logic [2:0]       m0_cti_i,
    input  logic [1:0]       m0_bte_i,
    input  logic             m0_we_i,
    input  logic             m0_cyc_i,
    input  logic             m0_stb_i,
    output logic [DAT_W-1:0] m0_dat_o,
    output logic             m0_ack_o,

    input  logic [DAT_W-1:0] m1_dat_i,
    input  logic [ADR_W-1:0] m1_adr_i,
    input  logic [3:0]       m1_sel_i,
    input  logic [2:0]       m1_cti_i,
    input  logic [1:0]       m1_bte_i,
    input  logic             m1_we_i,
    input  logic             m1_cyc_i,
    input  logic             m1_stb_i,
    output logic [DAT_W-1:0] m1_dat_o,
    output logic             m1_ack_o,

    output logic [DAT_W-1:0] s_dat_o,
    output logic [ADR_W-1:0] s_adr_o,
    output logic [3:0]       s_sel_o,
    output logic [2:0]       s_cti_o,
    output logic [1:0]       s_bte_o,
    output logic             s_we_o,
    output logic             s_cyc_o,
    output logic             s_stb_o,
    input  logic [DAT_W-1:0] s_dat_i,
    input  logic             s_ack_i,

    output logic [1:0]       gnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        last_q, last_d;   // 1: master 1 was served most recently
    logic [1:0]  gnt_q, gnt_d;

    logic req0, req1;
    logic end0, end1;

    assign req0 = m0_cyc_i & m0_stb_i;
    assign req1 = m1_cyc_i & m1_stb_i;

    // Classic cycle or end-of-burst marks the last beat of a transfer
    assign end0 = (m0_cti_i == 3'b000) || (m0_cti_i == 3'b111);
    assign end1 = (m1_cti_i == 3'b000) || (m1_cti_i == 3'b111);

    assign m0_ack_o = s_ack_i & (state_q == GNT0);
    assign m1_ack_o = s_ack_i & (state_q == GNT1);
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign gnt_o    = gnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            gnt_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
        end
    end

    // Every release goes through IDLE so the controller always sees a cycle boundary
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (req0 && (!req1 || last_q)) begin
                    state_d = GNT0;
                    last_d  = 1'b0;
                end else if (req1) begin
                    state_d = GNT1;
                    last_d  = 1'b1;
                end
            end
            GNT0: begin
                if (!m0_cyc_i || (m0_ack_o && end0)) state_d = IDLE;
            end
            GNT1: begin
                if (!m1_cyc_i || (m1_ack_o && end1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        gnt_d = {state_d == GNT1, state_d == GNT0};
    end

    // Slave-side mux; cyc/stb follow the owner's cyc so an abort drops them at once
    always_comb begin
        s_dat_o = '0;
        s_adr_o = '0;
        s_sel_o = '0;
        s_cti_o = '0;
        s_bte_o = '0;
        s_we_o  = 1'b0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        case (state_q)
            GNT0: begin
                s_dat_o = m0_dat_i;
                s_adr_o = m0_adr_i;
                s_sel_o = m0_sel_i;
                s_cti_o = m0_cti_i;
                s_bte_o = m0_bte_i;
                s_we_o  = m0_we_i;
                s_cyc_o = m0_cyc_i;
                s_stb_o = m0_stb_i & m0_cyc_i;
            end
            GNT1: begin
                s_dat_o = m1_dat_i;
                s_adr_o = m1_adr_i;
                s_sel_o = m1_sel_i;
                s_cti_o = m1_cti_i;
                s_bte_o = m1_bte_i;
                s_we_o  = m1_we_i;
                s_cyc_o = m1_cyc_i;
                s_stb_o = m1_stb_i & m1_cyc_i;
            end
            default: ;
        endcase
    end

endmodule
